ttt_game_ctrl: RTL
==================

TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: cycles a player may idle before forfeiting the turn; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1: clears the board and begins a game with X to move.
REQ-005 The block SHALL have port move_valid, input, 1: the current player presents a move.
REQ-006 The block SHALL have port move_pos, input, 4: cell index 0..8, where bit i of the board is cell i.
REQ-007 The block SHALL have port move_ready, output, 1: the block can accept a move this cycle.
REQ-008 The block SHALL have ports board_x and board_o, output, 9 each: registered occupancy per player.
REQ-009 The block SHALL have port turn, output, 1: 0 = X to move, 1 = O to move.
REQ-010 The block SHALL have port illegal, output, 1: one-cycle pulse when a presented move is rejected.
REQ-011 The block SHALL have port timeout, output, 1: one-cycle pulse when a turn is forfeited.
REQ-012 The block SHALL have port game_over, output, 1: high while in DONE.
REQ-013 The block SHALL have port winner, output, 2: 00 none, 01 X, 10 O, 11 draw.

Function
REQ-014 The FSM SHALL have states IDLE, TURN_X, TURN_O, CHECK and DONE.
REQ-015 move_ready SHALL be high only in TURN_X and TURN_O.
REQ-016 A move SHALL be accepted on the edge where move_valid and move_ready are both high.
REQ-017 An accepted move with move_pos at most 8 and the cell empty in both boards SHALL set that bit in the current player's board on the same edge, and the FSM SHALL go to CHECK.
REQ-018 An accepted move with move_pos above 8 or an occupied cell SHALL leave both boards unchanged, pulse illegal on the next cycle, and keep the same turn and state.
REQ-019 In CHECK, the FSM SHALL evaluate the registered boards and branch as follows:
- win for the mover: go to DONE with winner = 01 or 10;
- else both boards together fill all 9 cells: go to DONE with winner = 11;
- else: go to the other player's TURN state.
- Net latency from move acceptance to game_over is 2 edges.
REQ-020 turn SHALL toggle only when leaving CHECK to a TURN state or on timeout; it SHALL hold its value in CHECK and DONE.
REQ-021 DONE SHALL hold the boards and winner until start or reset; move_valid SHALL be ignored in DONE.
REQ-022 start SHALL take effect in any state and SHALL win over a simultaneous move_valid.
REQ-023 On start, the next edge SHALL clear both boards, set winner = 00, set turn = 0, and go to TURN_X.
REQ-024 The evaluator's both-players-win condition SHALL never occur; the bench asserts this.

Reset
REQ-025 When rst_n is low, the block SHALL go to IDLE with:
- board_x = 0 and board_o = 0;
- turn = 0, winner = 00;
- illegal, timeout, game_over and move_ready all 0;
- timeout counter = 0.
REQ-026 Reset SHALL abort any game in progress immediately, without waiting for a clock edge.
REQ-027 After reset is released, the block SHALL stay in IDLE until start.

Configuration
REQ-028 With TTT_MOVE_TIMEOUT_EN defined, the block SHALL include the timeout counter with this behaviour:
- it counts cycles in TURN_X/TURN_O;
- it clears on entering a TURN state and on any accepted move, legal or illegal;
- on reaching TIMEOUT_CYCLES, the turn passes to the other player's TURN state, timeout pulses, and the boards are unchanged.
REQ-029 Without TTT_MOVE_TIMEOUT_EN, the block SHALL have no counter, timeout SHALL be tied 0, and the port list SHALL be unchanged.

Structure
REQ-030 Package ttt_pkg SHALL hold:
- the FSM state enum;
- winner encodings;
- NUM_CELLS = 9;
- the 8 win-line masks as 9-bit constants.
REQ-031 Sub-module ttt_eval SHALL be a combinational evaluator: inputs are the two 9-bit boards; outputs are win_x, win_o, full, and both_win.
REQ-032 ttt_game_ctrl SHALL instantiate ttt_eval exactly once.

Verification
REQ-033 The bench SHALL cover these scenarios:
- X win: start, then X0, O3, X1, O4, X2 -> board_x = 000000111, board_o = 000011000, winner = 01, game_over 2 edges after the last accept.
- Draw: start, then X0, O1, X2, O4, X3, O5, X7, O6, X8 -> board_x = 110001101, board_o = 001110010, winner = 11.
- Illegal move: X0, then O presents 0, then O presents 9 -> two illegal pulses, turn = 1, board_o = 0; then O4 is accepted.
- Timeout: macro defined, TIMEOUT_CYCLES = 4, start, move_valid low -> timeout pulses once, turn = 1, boards remain 0.
- Reset and restart: rst_n low mid-game after 3 moves -> all outputs at reset values asynchronously; start together with move_valid in DONE -> boards cleared, no move applied.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Holds the FSM state enum, winner encodings, the cell count and the eight
// win-line masks (bit i of a mask is board cell i).
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN_X,
    ST_TURN_O,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Three rows, three columns, two diagonals.
  localparam logic [7:0][NUM_CELLS-1:0] WIN_MASKS = {
    9'b000_000_111,
    9'b000_111_000,
    9'b111_000_000,
    9'b001_001_001,
    9'b010_010_010,
    9'b100_100_100,
    9'b100_010_001,
    9'b001_010_100
  };

endpackage

// File: rtl/ttt_eval.sv
// Purpose     : combinational board evaluator (wins per player, board full).
// Latency     : zero cycles, purely combinational.
// Backpressure: none, no handshake.
// Ports: board_x/board_o in (9b occupancy); win_x, win_o, full, both_win out.
module ttt_eval
  import ttt_pkg::*;
(
  input  logic [NUM_CELLS-1:0] board_x,
  input  logic [NUM_CELLS-1:0] board_o,
  output logic                 win_x,
  output logic                 win_o,
  output logic                 full,
  output logic                 both_win
);

  always_comb begin
    win_x = 1'b0;
    win_o = 1'b0;
    for (int i = 0; i < 8; i++) begin
      win_x = win_x | ((board_x & WIN_MASKS[i]) == WIN_MASKS[i]);
      win_o = win_o | ((board_o & WIN_MASKS[i]) == WIN_MASKS[i]);
    end
  end

  assign full     = &(board_x | board_o);
  // Only reachable if the controller ever let a player move after a win.
  assign both_win = win_x & win_o;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Purpose     : tic-tac-toe game controller (move legality, turns, win/draw).
// Latency     : legal move accept -> CHECK next edge -> DONE/next turn 2nd edge.
// Backpressure: move_ready high only in TURN_X/TURN_O; start overrides moves.
// Ports: clk, rst_n (async active-low), start, move_valid, move_pos[3:0] in;
//        move_ready, board_x/board_o[8:0], turn, illegal, timeout, game_over,
//        winner[1:0] out.
// Optional: define TTT_MOVE_TIMEOUT_EN to add the idle-turn forfeit counter;
//           otherwise timeout is tied low and no counter exists.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 move_valid,
  input  logic [3:0]           move_pos,
  output logic                 move_ready,
  output logic [NUM_CELLS-1:0] board_x,
  output logic [NUM_CELLS-1:0] board_o,
  output logic                 turn,
  output logic                 illegal,
  output logic                 timeout,
  output logic                 game_over,
  output logic [1:0]           winner
);

  state_t               state, state_nxt;
  logic [NUM_CELLS-1:0] board_x_nxt, board_o_nxt;
  logic                 turn_nxt, illegal_nxt, timeout_nxt;
  logic [1:0]           winner_nxt;
  logic                 win_x, win_o, full, both_win;
  logic                 accept, legal, expire;
  logic [15:0]          pos_onehot;
  logic [NUM_CELLS-1:0] cell_mask;

  ttt_eval u_eval (
    .board_x  (board_x),
    .board_o  (board_o),
    .win_x    (win_x),
    .win_o    (win_o),
    .full     (full),
    .both_win (both_win)
  );

  assign move_ready = (state == ST_TURN_X) || (state == ST_TURN_O);
  assign game_over  = (state == ST_DONE);
  assign accept     = move_valid && move_ready && !start;

  // One-hot decode over 16 positions so out-of-range indices never slice
  // past the 9-bit board.
  assign pos_onehot = 16'd1 << move_pos;
  assign cell_mask  = pos_onehot[NUM_CELLS-1:0];
  assign legal      = (move_pos <= 4'd8) && ((cell_mask & (board_x | board_o)) == '0);

`ifdef TTT_MOVE_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  assign expire = move_ready && !accept && !start &&
                  (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Outside TURN states the counter sits at zero, so every TURN entry
  // starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (start || accept || expire || !move_ready) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    board_x_nxt = board_x;
    board_o_nxt = board_o;
    turn_nxt    = turn;
    winner_nxt  = winner;
    illegal_nxt = 1'b0;
    timeout_nxt = 1'b0;
    if (start) begin
      state_nxt   = ST_TURN_X;
      board_x_nxt = '0;
      board_o_nxt = '0;
      turn_nxt    = 1'b0;
      winner_nxt  = WIN_NONE;
    end else begin
      case (state)
        ST_TURN_X, ST_TURN_O: begin
          if (accept) begin
            if (legal) begin
              if (state == ST_TURN_X) board_x_nxt = board_x | cell_mask;
              else                    board_o_nxt = board_o | cell_mask;
              state_nxt = ST_CHECK;
            end else begin
              illegal_nxt = 1'b1;
            end
          end else if (expire) begin
            state_nxt   = (state == ST_TURN_X) ? ST_TURN_O : ST_TURN_X;
            turn_nxt    = ~turn;
            timeout_nxt = 1'b1;
          end
        end
        ST_CHECK: begin
          // turn still names the player who just moved.
          if (turn ? win_o : win_x) begin
            state_nxt  = ST_DONE;
            winner_nxt = turn ? WIN_O : WIN_X;
          end else if (full) begin
            state_nxt  = ST_DONE;
            winner_nxt = WIN_DRAW;
          end else begin
            state_nxt = turn ? ST_TURN_X : ST_TURN_O;
            turn_nxt  = ~turn;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      board_x <= '0;
      board_o <= '0;
      turn    <= 1'b0;
      winner  <= WIN_NONE;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      board_x <= board_x_nxt;
      board_o <= board_o_nxt;
      turn    <= turn_nxt;
      winner  <= winner_nxt;
      illegal <= illegal_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule
